matrix_feeder: RTL

- Host-side transmitter for the matrix-multiply datapath.
- Accepts operand words from a host over a valid/ready interface and buffers them into frames of 12 words in two ping-pong banks.
- Emits the cf_load start pulse, then streams each frame one word per clock on din, in the index order the multiplier controller's 1-to-12 demux consumes (index 0 first).
- Subsequent frames are released on the datapath's next_req pulse, so the host can fill one bank while the other streams.

---
 rtl/matrix_feeder.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/matrix_feeder.sv
// matrix_feeder
//   Host-side transmitter for the matrix-multiply datapath. Host words arrive
//   on a valid/ready port and are collected into FRAME_LEN-word frames held in
//   two ping-pong banks. The first complete frame is announced with a one-cycle
//   cf_load pulse. Every frame is streamed one word per clock, index 0 first.
//   Frames after the first are released by next_req pulses from the datapath.
//
// Ports
//   clk        rising-edge clock
//   reset      synchronous, active-low reset
//   in_data    host operand word
//   in_valid   host word valid
//   in_ready   feeder can accept in_data this cycle (fill bank not full)
//   next_req   one-cycle request for the next frame
//   cf_load    one-cycle start pulse to the multiplier controller (first frame)
//   din        operand word to datapath (holds its value while idle)
//   din_valid  din carries a frame word
//   din_idx    index of the word on din (0 while idle)
//   frame_done pulse coincident with the last word of each frame
module matrix_feeder #(
  parameter int DATA_W    = 16,
  parameter int FRAME_LEN = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              next_req,
  output logic              cf_load,
  output logic [DATA_W-1:0] din,
  output logic              din_valid,
  output logic [3:0]        din_idx,
  output logic              frame_done
);

  localparam logic [3:0] LAST_IDX = 4'(FRAME_LEN - 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    WAIT_REQ,
    STREAM
  } state_e;

  logic [DATA_W-1:0] mem_q [2][FRAME_LEN];

  state_e            state_q, state_d;
  logic [1:0]        full_q, full_d;
  logic              fill_bank_q, fill_bank_d;
  logic              stream_bank_q, stream_bank_d;
  logic [3:0]        wr_cnt_q, wr_cnt_d;
  logic [3:0]        rd_cnt_q, rd_cnt_d;
  logic              first_q, first_d;
  logic              pend_q, pend_d;
  logic              in_ready_q, in_ready_d;
  logic              cf_load_q, cf_load_d;
  logic [DATA_W-1:0] din_q, din_d;
  logic              din_valid_q, din_valid_d;
  logic [3:0]        din_idx_q, din_idx_d;
  logic              frame_done_q, frame_done_d;
  logic              wr_en;

  // in_ready_q mirrors the current fill-bank status, so it can qualify writes.
  assign wr_en = in_valid && in_ready_q;

  always_comb begin
    full_d        = full_q;
    fill_bank_d   = fill_bank_q;
    wr_cnt_d      = wr_cnt_q;
    state_d       = state_q;
    stream_bank_d = stream_bank_q;
    rd_cnt_d      = rd_cnt_q;
    first_d       = first_q;
    pend_d        = pend_q;

    // Fill side
    if (wr_en) begin
      if (wr_cnt_q == LAST_IDX) begin
        full_d[fill_bank_q] = 1'b1;
        wr_cnt_d            = '0;
        fill_bank_d         = ~fill_bank_q;
      end else begin
        wr_cnt_d = wr_cnt_q + 4'd1;
      end
    end

    // Stream side. The fill side only sets the flag of a non-full bank and the
    // stream side only clears the flag of a full bank, so they never collide.
    unique case (state_q)
      IDLE: begin
        if (full_q[stream_bank_q]) begin
          state_d = first_q ? START : WAIT_REQ;
        end else if (next_req && !first_q) begin
          pend_d = 1'b1;
        end
      end
      START: begin
        first_d  = 1'b0;
        rd_cnt_d = '0;
        state_d  = STREAM;
      end
      WAIT_REQ: begin
        if (pend_q || next_req) begin
          pend_d   = 1'b0;
          rd_cnt_d = '0;
          state_d  = STREAM;
        end
      end
      STREAM: begin
        if (next_req) pend_d = 1'b1;
        if (rd_cnt_q == LAST_IDX) begin
          full_d[stream_bank_q] = 1'b0;
          stream_bank_d         = ~stream_bank_q;
          rd_cnt_d              = '0;
          state_d               = IDLE;
        end else begin
          rd_cnt_d = rd_cnt_q + 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Outputs are decoded from next-state values and then registered, giving
    // a Moore view of state_q with no combinational input-to-output path.
    in_ready_d   = !full_d[fill_bank_d];
    cf_load_d    = (state_d == START);
    din_valid_d  = (state_d == STREAM);
    din_idx_d    = din_valid_d ? rd_cnt_d : '0;
    din_d        = din_valid_d ? mem_q[stream_bank_d][rd_cnt_d] : din_q;
    frame_done_d = din_valid_d && (rd_cnt_d == LAST_IDX);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= IDLE;
      full_q        <= '0;
      fill_bank_q   <= 1'b0;
      stream_bank_q <= 1'b0;
      wr_cnt_q      <= '0;
      rd_cnt_q      <= '0;
      first_q       <= 1'b1;
      pend_q        <= 1'b0;
      in_ready_q    <= 1'b0;
      cf_load_q     <= 1'b0;
      din_q         <= '0;
      din_valid_q   <= 1'b0;
      din_idx_q     <= '0;
      frame_done_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      full_q        <= full_d;
      fill_bank_q   <= fill_bank_d;
      stream_bank_q <= stream_bank_d;
      wr_cnt_q      <= wr_cnt_d;
      rd_cnt_q      <= rd_cnt_d;
      first_q       <= first_d;
      pend_q        <= pend_d;
      in_ready_q    <= in_ready_d;
      cf_load_q     <= cf_load_d;
      din_q         <= din_d;
      din_valid_q   <= din_valid_d;
      din_idx_q     <= din_idx_d;
      frame_done_q  <= frame_done_d;
    end
  end

  // Frame storage needs no reset: the full flags gate every read.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[fill_bank_q][wr_cnt_q] <= in_data;
  end

  assign in_ready   = in_ready_q;
  assign cf_load    = cf_load_q;
  assign din        = din_q;
  assign din_valid  = din_valid_q;
  assign din_idx    = din_idx_q;
  assign frame_done = frame_done_q;

endmodule
